// File: rtl/prf_mp_if.sv
// Bus bundle for prf_mp: rename alloc, read ports, writeback, commit and flush recovery.
interface prf_mp_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_PREG = 32,
  parameter int unsigned NUM_AREG = 8,
  parameter int unsigned NUM_RD   = 4,
  parameter int unsigned NUM_WB   = 2
);
  localparam int unsigned TAG_W = $clog2(NUM_PREG);

  logic                       stop;
  logic                       flush;
  logic                       alloc_req;
  logic                       alloc_gnt;
  logic [TAG_W-1:0]           alloc_tag;
  logic                       full;
  logic [TAG_W:0]             free_cnt;
  logic [NUM_RD*TAG_W-1:0]    rd_tag;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_ready;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*TAG_W-1:0]    wb_tag;
  logic [NUM_WB*DATA_W-1:0]   wb_data;
  logic                       cmt_valid;
  logic [TAG_W-1:0]           cmt_tag_old;
  logic [NUM_AREG*TAG_W-1:0]  arch_tag;

  modport master (
    output stop, flush, alloc_req, rd_tag, wb_valid, wb_tag, wb_data,
           cmt_valid, cmt_tag_old, arch_tag,
    input  alloc_gnt, alloc_tag, full, free_cnt, rd_data, rd_ready
  );

  modport slave (
    input  stop, flush, alloc_req, rd_tag, wb_valid, wb_tag, wb_data,
           cmt_valid, cmt_tag_old, arch_tag,
    output alloc_gnt, alloc_tag, full, free_cnt, rd_data, rd_ready
  );
endinterface

// File: rtl/prf_mp.sv
// Multi-port physical register file with free list and ready scoreboard for rename/issue.
// Optional PRF_WB_BYPASS_EN: same-cycle forwarding of writeback data onto read ports.
module prf_mp #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_PREG = 32,
  parameter int unsigned NUM_AREG = 8,
  parameter int unsigned NUM_RD   = 4,
  parameter int unsigned NUM_WB   = 2
) (
  input logic    clk,
  input logic    rst,
  prf_mp_if.slave bus
);
  localparam int unsigned TAG_W = $clog2(NUM_PREG);
  localparam int unsigned CNT_W = TAG_W + 1;

  logic [DATA_W-1:0]   data_q [NUM_PREG];
  logic [DATA_W-1:0]   data_d [NUM_PREG];
  logic [NUM_PREG-1:0] free_q, free_d;
  logic [NUM_PREG-1:0] ready_q, ready_d;
  logic [CNT_W-1:0]    free_cnt_q, free_cnt_d;

  logic [TAG_W-1:0]         alloc_tag;
  logic                     alloc_gnt;
  logic                     full;
  logic                     cmt_free;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_ready_c;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PREG-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_PREG; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Lowest-index free tag; tag 0 is never free so it doubles as the "none" value.
  always_comb begin
    alloc_tag = '0;
    for (int unsigned i = NUM_PREG - 1; i > 0; i--) begin
      if (free_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign full      = (free_cnt_q == '0);
  assign alloc_gnt = bus.alloc_req & ~full & ~bus.stop & ~bus.flush;
  assign cmt_free  = bus.cmt_valid & (bus.cmt_tag_old != '0);

  always_comb begin
    data_d     = data_q;
    free_d     = free_q;
    ready_d    = ready_q;
    free_cnt_d = free_cnt_q;
    if (bus.flush) begin
      // Everything not named by the committed map goes back to the pool.
      free_d     = '1;
      free_d[0]  = 1'b0;
      ready_d[0] = 1'b1;
      for (int unsigned a = 0; a < NUM_AREG; a++) begin
        free_d[bus.arch_tag[a*TAG_W +: TAG_W]]  = 1'b0;
        ready_d[bus.arch_tag[a*TAG_W +: TAG_W]] = 1'b1;
      end
      free_cnt_d = popcount(free_d);
    end else if (!bus.stop) begin
      // Ascending port order lets the highest port win a same-tag collision.
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (bus.wb_valid[k] && (bus.wb_tag[k*TAG_W +: TAG_W] != '0)) begin
          data_d[bus.wb_tag[k*TAG_W +: TAG_W]]  = bus.wb_data[k*DATA_W +: DATA_W];
          ready_d[bus.wb_tag[k*TAG_W +: TAG_W]] = 1'b1;
        end
      end
      if (alloc_gnt) begin
        free_d[alloc_tag]  = 1'b0;
        ready_d[alloc_tag] = 1'b0;
      end
      if (cmt_free) free_d[bus.cmt_tag_old] = 1'b1;
      free_cnt_d = free_cnt_q + CNT_W'(cmt_free) - CNT_W'(alloc_gnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREG; i++) begin
        data_q[i]  <= DATA_W'(i);
        free_q[i]  <= (i >= NUM_AREG) && (i != 0);
        ready_q[i] <= (i < NUM_AREG) || (i == 0);
      end
      free_cnt_q <= CNT_W'(NUM_PREG - NUM_AREG);
    end else begin
      data_q     <= data_d;
      free_q     <= free_d;
      ready_q    <= ready_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  always_comb begin
    rd_data_c  = '0;
    rd_ready_c = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_data_c[p*DATA_W +: DATA_W] = data_q[bus.rd_tag[p*TAG_W +: TAG_W]];
      rd_ready_c[p]                 = ready_q[bus.rd_tag[p*TAG_W +: TAG_W]];
`ifdef PRF_WB_BYPASS_EN
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (bus.wb_valid[k] && (bus.wb_tag[k*TAG_W +: TAG_W] != '0) &&
            (bus.wb_tag[k*TAG_W +: TAG_W] == bus.rd_tag[p*TAG_W +: TAG_W])) begin
          rd_data_c[p*DATA_W +: DATA_W] = bus.wb_data[k*DATA_W +: DATA_W];
          rd_ready_c[p]                 = 1'b1;
        end
      end
`else
      // Stored array only: a writeback becomes visible one cycle later.
      rd_ready_c[p] = rd_ready_c[p];
`endif
    end
  end

  assign bus.alloc_gnt = alloc_gnt;
  assign bus.alloc_tag = alloc_tag;
  assign bus.full      = full;
  assign bus.free_cnt  = free_cnt_q;
  assign bus.rd_data   = rd_data_c;
  assign bus.rd_ready  = rd_ready_c;

`ifndef SYNTHESIS
  // Protocol misuse by the core: double free, or writeback into an unallocated tag.
  always @(posedge clk) begin
    if (!rst && !bus.flush && !bus.stop) begin
      assert (!(cmt_free && free_q[bus.cmt_tag_old]))
        else $error("prf_mp: commit frees already-free tag %0d", bus.cmt_tag_old);
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        assert (!(bus.wb_valid[k] && (bus.wb_tag[k*TAG_W +: TAG_W] != '0) &&
                  free_q[bus.wb_tag[k*TAG_W +: TAG_W]]))
          else $error("prf_mp: writeback port %0d targets free tag %0d", k,
                      bus.wb_tag[k*TAG_W +: TAG_W]);
      end
    end
  end
`endif
endmodule

// File: tb/tb_prf_mp.sv
// Directed self-checking bench for prf_mp: alloc/full, commit free, writeback, bypass, flush, stop, reset.
module tb_prf_mp;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  prf_mp_if #(.DATA_W(16), .NUM_PREG(32), .NUM_AREG(8), .NUM_RD(4), .NUM_WB(2)) bus ();

  prf_mp #(.DATA_W(16), .NUM_PREG(32), .NUM_AREG(8), .NUM_RD(4), .NUM_WB(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input int tag);
    bus.rd_tag[p*TW +: TW] = TW'(tag);
  endtask

  function automatic logic [31:0] rdd(input int p);
    return 32'(bus.rd_data[p*DW +: DW]);
  endfunction

  function automatic logic [31:0] rdr(input int p);
    return 32'(bus.rd_ready[p]);
  endfunction

  task automatic wb(input int k, input int tag, input int data);
    bus.wb_tag[k*TW +: TW]  = TW'(tag);
    bus.wb_data[k*DW +: DW] = DW'(data);
  endtask

  task automatic idle_inputs();
    bus.stop        = 1'b0;
    bus.flush       = 1'b0;
    bus.alloc_req   = 1'b0;
    bus.wb_valid    = '0;
    bus.cmt_valid   = 1'b0;
    bus.cmt_tag_old = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    bus.rd_tag   = '0;
    bus.wb_tag   = '0;
    bus.wb_data  = '0;
    bus.arch_tag = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    rd(0, 0); rd(1, 3); rd(2, 8); rd(3, 31);
    #1;
    check("rst_free_cnt", 32'(bus.free_cnt), 24);
    check("rst_full", 32'(bus.full), 0);
    check("rst_alloc_tag", 32'(bus.alloc_tag), 8);
    check("rst_rd0_data", rdd(0), 0);
    check("rst_rd0_ready", rdr(0), 1);
    check("rst_rd1_data", rdd(1), 3);
    check("rst_rd1_ready", rdr(1), 1);
    check("rst_rd2_ready", rdr(2), 0);
    check("rst_rd3_data", rdd(3), 31);
    check("rst_rd3_ready", rdr(3), 0);

    // 1: drain the free list in tag order
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      #1;
      check("t1_gnt", 32'(bus.alloc_gnt), 1);
      check("t1_tag", 32'(bus.alloc_tag), 32'(8 + i));
      tick();
    end
    #1;
    check("t1_full", 32'(bus.full), 1);
    check("t1_free_cnt", 32'(bus.free_cnt), 0);
    check("t1_gnt_full", 32'(bus.alloc_gnt), 0);
    check("t1_tag_full", 32'(bus.alloc_tag), 0);

    // 2: commit frees tag 5, usable only from the next cycle
    bus.cmt_valid   = 1'b1;
    bus.cmt_tag_old = 5'd5;
    #1;
    check("t2_gnt_same_cycle", 32'(bus.alloc_gnt), 0);
    tick();
    bus.cmt_valid = 1'b0;
    #1;
    check("t2_free_cnt", 32'(bus.free_cnt), 1);
    check("t2_full", 32'(bus.full), 0);
    check("t2_alloc_tag", 32'(bus.alloc_tag), 5);
    check("t2_gnt", 32'(bus.alloc_gnt), 1);
    tick();
    bus.alloc_req = 1'b0;
    #1;
    check("t2_refull", 32'(bus.full), 1);

    // 3: two ports hit tag 12, port 1 wins
    rd(0, 12);
    bus.wb_valid = 2'b11;
    wb(0, 12, 'h1234);
    wb(1, 12, 'hBEEF);
    #1;
`ifdef PRF_WB_BYPASS_EN
    check("t3_byp_data", rdd(0), 'hBEEF);
    check("t3_byp_ready", rdr(0), 1);
`else
    check("t3_old_data", rdd(0), 12);
    check("t3_old_ready", rdr(0), 0);
`endif
    tick();
    bus.wb_valid = '0;
    #1;
    check("t3_data", rdd(0), 'hBEEF);
    check("t3_ready", rdr(0), 1);

    // 4: write tag 13 while reading it; write to tag 0 is dropped
    rd(0, 13); rd(1, 0);
    bus.wb_valid = 2'b11;
    wb(0, 13, 'hAAAA);
    wb(1, 0, 'h5555);
    #1;
`ifdef PRF_WB_BYPASS_EN
    check("t4_byp_data", rdd(0), 'hAAAA);
    check("t4_byp_ready", rdr(0), 1);
`else
    check("t4_old_data", rdd(0), 13);
    check("t4_old_ready", rdr(0), 0);
`endif
    check("t4_zero_data_now", rdd(1), 0);
    check("t4_zero_ready", rdr(1), 1);
    tick();
    bus.wb_valid = '0;
    #1;
    check("t4_data", rdd(0), 'hAAAA);
    check("t4_ready", rdr(0), 1);
    check("t4_zero_data", rdd(1), 0);

    // 5: flush rebuilds the free list; grant, writeback and commit are dropped
    for (int a = 0; a < 7; a++) bus.arch_tag[a*TW +: TW] = TW'(a);
    bus.arch_tag[7*TW +: TW] = 5'd10;
    bus.flush       = 1'b1;
    bus.alloc_req   = 1'b1;
    bus.cmt_valid   = 1'b1;
    bus.cmt_tag_old = 5'd20;
    bus.wb_valid    = 2'b01;
    wb(0, 9, 'h9999);
    #1;
    check("t5_gnt_flush", 32'(bus.alloc_gnt), 0);
    tick();
    idle_inputs();
    rd(0, 10); rd(1, 9); rd(2, 13); rd(3, 20);
    #1;
    check("t5_free_cnt", 32'(bus.free_cnt), 24);
    check("t5_full", 32'(bus.full), 0);
    check("t5_alloc_tag", 32'(bus.alloc_tag), 7);
    check("t5_arch_ready", rdr(0), 1);
    check("t5_wb_dropped_data", rdd(1), 9);
    check("t5_wb_dropped_ready", rdr(1), 0);
    check("t5_data_kept", rdd(2), 'hAAAA);
    check("t5_ready_20", rdr(3), 0);
    bus.alloc_req = 1'b1;
    #1;
    check("t5_gnt7", 32'(bus.alloc_gnt), 1);
    check("t5_gnt7_tag", 32'(bus.alloc_tag), 7);
    tick();
    bus.alloc_req = 1'b0;
    #1;
    check("t5_cnt23", 32'(bus.free_cnt), 23);
    check("t5_next_tag", 32'(bus.alloc_tag), 8);

    // 6: stop holds every piece of state
    bus.stop        = 1'b1;
    bus.alloc_req   = 1'b1;
    bus.wb_valid    = 2'b11;
    wb(0, 9, 'h4242);
    wb(1, 0, 'hFFFF);
    bus.cmt_valid   = 1'b1;
    bus.cmt_tag_old = 5'd3;
    #1;
    check("t6_gnt_stop", 32'(bus.alloc_gnt), 0);
    tick();
    #1;
    check("t6_gnt_stop2", 32'(bus.alloc_gnt), 0);
    tick();
    idle_inputs();
    rd(0, 9); rd(1, 0); rd(2, 3);
    #1;
    check("t6_free_cnt", 32'(bus.free_cnt), 23);
    check("t6_alloc_tag", 32'(bus.alloc_tag), 8);
    check("t6_data9", rdd(0), 9);
    check("t6_ready9", rdr(0), 0);
    check("t6_data0", rdd(1), 0);
    check("t6_ready3", rdr(2), 1);

    // Commit of tag 0 is ignored
    bus.cmt_valid   = 1'b1;
    bus.cmt_tag_old = 5'd0;
    tick();
    bus.cmt_valid = 1'b0;
    #1;
    check("cmt0_free_cnt", 32'(bus.free_cnt), 23);

    // Grant and free together leave the count unchanged
    bus.alloc_req   = 1'b1;
    bus.cmt_valid   = 1'b1;
    bus.cmt_tag_old = 5'd3;
    #1;
    check("both_gnt", 32'(bus.alloc_gnt), 1);
    check("both_tag", 32'(bus.alloc_tag), 8);
    tick();
    idle_inputs();
    #1;
    check("both_free_cnt", 32'(bus.free_cnt), 23);
    check("both_next_tag", 32'(bus.alloc_tag), 3);

    // Reset mid-operation wins over a pending grant
    rst           = 1'b1;
    bus.alloc_req = 1'b1;
    tick();
    rst           = 1'b0;
    bus.alloc_req = 1'b0;
    rd(0, 13);
    #1;
    check("mrst_free_cnt", 32'(bus.free_cnt), 24);
    check("mrst_alloc_tag", 32'(bus.alloc_tag), 8);
    check("mrst_data13", rdd(0), 13);
    check("mrst_ready13", rdr(0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
